flash_reader: RTL and testbench
===============================

Name: flash_reader

Overview:
- Avalon-MM read master that fetches 32-bit sample words from flash and hands each word to audio_player.
- Each word carries two 16-bit samples.
- Walks the song address range forward or backward and applies play/pause.
- Runs on the 50 MHz system clock; the audio_player start/finished strobes arrive already synchronised to this clock.

Parameters:
- ADDR_W, 23, flash word-address width.
- START_ADDR, 23'h0, first word of the song.
- END_ADDR, 23'h7FFFF, last word of the song (inclusive).

Ports:
- clk_50MHz  in  1  system clock.
- reset  in  1  synchronous, active-high.
- play  in  1  level; 1 = run, 0 = pause.
- forward  in  1  level; 1 = address increments, 0 = address decrements.
- restart  in  1  pulse; jump to the song boundary.
- flash_mem_read  out  1  Avalon read request.
- flash_mem_address  out  ADDR_W  Avalon word address.
- flash_mem_byteenable  out  4  constant 4'b1111.
- flash_mem_waitrequest  in  1  Avalon stall.
- flash_mem_readdata  in  32  Avalon read data.
- flash_mem_readdatavalid  in  1  Avalon data strobe.
- sample_word  out  32  latched word for audio_player.
- player_start  out  1  one-cycle pulse: sample_word is valid.
- player_finished  in  1  one-cycle pulse: both samples consumed.
- song_done  out  1  level; end of song reached (LOOP_EN off only).

Behaviour:
- Reset values:
  - flash_mem_read=0, player_start=0, song_done=0.
  - sample_word=0.
  - flash_mem_address=START_ADDR.
  - State=IDLE.
- Reset takes priority over everything, including a transaction already in flight. Any readdatavalid arriving after reset is ignored because the FSM is in IDLE.
- IDLE: when play=1, go to REQ.
- REQ:
  - Assert flash_mem_read with the address stable.
  - Hold both until a cycle with waitrequest=0, then deassert read and go to WAIT_DATA.
- WAIT_DATA:
  - On readdatavalid, latch readdata into sample_word and go to HANDOFF.
  - There is no timeout.
- HANDOFF: player_start=1 for exactly one cycle, then go to WAIT_DONE.
- WAIT_DONE: on player_finished go to STEP. A finished pulse in any other state is ignored.
- STEP, forward=1:
  - If address==END_ADDR, wrap to START_ADDR; otherwise address+1.
- STEP, forward=0:
  - If address==START_ADDR, wrap to END_ADDR; otherwise address-1.
- After STEP: if play=1 go to REQ, else go to IDLE.
- Direction is sampled only in STEP. Changing forward mid-word does not affect the current word.
- play=0 is honoured only at the IDLE/STEP decision points. A read already issued always completes and its word is still handed off.
- restart:
  - Registered as pending.
  - Applied in the next STEP instead of the normal increment/decrement: address=START_ADDR when forward=1, END_ADDR when forward=0.
  - Also clears song_done.
  - restart in IDLE applies immediately.
- restart coinciding with player_finished: restart wins and the boundary address is loaded.
- Latency, idle memory (waitrequest=0, readdatavalid one cycle after accept):
  - play rising to first player_start = 4 cycles.
  - player_finished to next flash_mem_read = 2 cycles.
- Address arithmetic is ADDR_W bits, unsigned. No compare is ever made outside [START_ADDR, END_ADDR].

Optional Feature:
- Macro: FLASH_READER_LOOP_EN.
- Defined: wrap-around as described above; song_done is tied to 0.
- Undefined:
  - At the boundary, STEP does not wrap; it sets song_done=1 and goes to IDLE.
  - The block stays in IDLE regardless of play until restart or reset.

Decomposition:
- Package flash_reader_pkg holds:
  - typedef enum logic [2:0] state_t {IDLE, REQ, WAIT_DATA, HANDOFF, WAIT_DONE, STEP}.
  - Localparams for the default START_ADDR/END_ADDR.
  - The byteenable constant.
- One sub-module, flash_addr_stepper: combinational next-address plus registered address, taking step, forward, restart and the bounds.

Test Plan:
- Reset, play=1, forward=1, zero-wait memory returning 32'hFFFF_1111:
  - flash_mem_read at address 0.
  - player_start 4 cycles after play.
  - sample_word=32'hFFFF_1111.
  - After player_finished, next read at address 1.
- waitrequest held high 5 cycles:
  - flash_mem_read and the address stay stable for all 6 cycles.
  - Exactly one transaction is issued.
- forward=0 at address START_ADDR, word 32'h3333_CCCC delivered, then finished:
  - Next read address = END_ADDR (loop build).
  - Without FLASH_READER_LOOP_EN: song_done=1, no further read.
- play drops during WAIT_DATA:
  - Word still delivered with a player_start pulse.
  - After finished, address steps and the FSM idles with no new read.
  - play=1 resumes at the stepped address.
- restart and player_finished in the same cycle at address 0x100, forward=1: next read address=START_ADDR.
- reset asserted in WAIT_DATA, then a stray readdatavalid:
  - No player_start.
  - Outputs at reset values.
  - flash_mem_address=START_ADDR.

Source files
------------

// File: rtl/flash_reader_pkg.sv
// flash_reader shared types and constants.
// State encoding, default song bounds, byteenable.
package flash_reader_pkg;

  localparam int         DEF_ADDR_W     = 23;
  localparam logic [22:0] DEF_START_ADDR = 23'h0;
  localparam logic [22:0] DEF_END_ADDR   = 23'h7FFFF;
  localparam logic [3:0]  FLASH_BYTE_EN  = 4'b1111;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    HANDOFF,
    WAIT_DONE,
    STEP
  } state_t;

endpackage

// File: rtl/flash_reader_if.sv
// Avalon-MM read bus between flash_reader and flash.
// master: read/address/byteenable out; slave: the reverse.
interface flash_reader_if #(
  parameter int ADDR_W = 23
);

  logic              flash_mem_read;
  logic [ADDR_W-1:0] flash_mem_address;
  logic [3:0]        flash_mem_byteenable;
  logic              flash_mem_waitrequest;
  logic [31:0]       flash_mem_readdata;
  logic              flash_mem_readdatavalid;

  modport master (
    output flash_mem_read,
    output flash_mem_address,
    output flash_mem_byteenable,
    input  flash_mem_waitrequest,
    input  flash_mem_readdata,
    input  flash_mem_readdatavalid
  );

  modport slave (
    input  flash_mem_read,
    input  flash_mem_address,
    input  flash_mem_byteenable,
    output flash_mem_waitrequest,
    output flash_mem_readdata,
    output flash_mem_readdatavalid
  );

endinterface

// File: rtl/flash_addr_stepper.sv
// Song word-address register with wrap/restart next-address.
// In: step, forward, restart. Out: addr, at_bound.
module flash_addr_stepper
  import flash_reader_pkg::*;
#(
  parameter int              ADDR_W     = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(DEF_START_ADDR),
  parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(DEF_END_ADDR)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step,
  input  logic              forward,
  input  logic              restart,
  output logic [ADDR_W-1:0] addr,
  output logic              at_bound
);

  logic [ADDR_W-1:0] addr_n;
  logic [ADDR_W-1:0] target;

  // Restart and wrap both land on the boundary
  // the walk direction starts from.
  always_comb begin
    target   = forward ? START_ADDR : END_ADDR;
    at_bound = forward ? (addr == END_ADDR)
                       : (addr == START_ADDR);
    addr_n   = addr;
    if (restart)
      addr_n = target;
    else if (step)
      addr_n = at_bound ? target
             : forward  ? addr + ADDR_W'(1)
                        : addr - ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) addr <= START_ADDR;
    else       addr <= addr_n;
  end

endmodule

// File: rtl/flash_reader.sv
// Avalon-MM flash read master feeding audio_player words.
// Ports: clk_50MHz, reset, play, forward, restart,
//   flash_mem (flash_reader_if.master), sample_word,
//   player_start, player_finished, song_done.
// FLASH_READER_LOOP_EN: wrap at song end, song_done tied 0.
module flash_reader
  import flash_reader_pkg::*;
#(
  parameter int              ADDR_W     = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] START_ADDR = ADDR_W'(DEF_START_ADDR),
  parameter logic [ADDR_W-1:0] END_ADDR   = ADDR_W'(DEF_END_ADDR)
) (
  input  logic                  clk_50MHz,
  input  logic                  reset,
  input  logic                  play,
  input  logic                  forward,
  input  logic                  restart,
  flash_reader_if.master        flash_mem,
  output logic [31:0]           sample_word,
  output logic                  player_start,
  input  logic                  player_finished,
  output logic                  song_done
);

`ifdef FLASH_READER_LOOP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  state_t state, state_n;

  logic              rst_pend;
  logic              rst_any;
  logic              step_en;
  logic              load_en;
  logic              done_set;
  logic              at_bound;
  logic [ADDR_W-1:0] addr;

  assign rst_any = restart | rst_pend;

  flash_addr_stepper #(
    .ADDR_W     (ADDR_W),
    .START_ADDR (START_ADDR),
    .END_ADDR   (END_ADDR)
  ) u_step (
    .clk      (clk_50MHz),
    .reset    (reset),
    .step     (step_en),
    .forward  (forward),
    .restart  (load_en),
    .addr     (addr),
    .at_bound (at_bound)
  );

  assign flash_mem.flash_mem_address    = addr;
  assign flash_mem.flash_mem_byteenable = FLASH_BYTE_EN;

  always_ff @(posedge clk_50MHz) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n                  = state;
    step_en                  = 1'b0;
    load_en                  = 1'b0;
    done_set                 = 1'b0;
    flash_mem.flash_mem_read = 1'b0;
    unique case (state)
      IDLE: begin
        load_en = rst_any;
        // A finished song parks here until restart.
        if (play && (!song_done || rst_any))
          state_n = REQ;
      end
      REQ: begin
        flash_mem.flash_mem_read = 1'b1;
        if (!flash_mem.flash_mem_waitrequest)
          state_n = WAIT_DATA;
      end
      WAIT_DATA: begin
        if (flash_mem.flash_mem_readdatavalid)
          state_n = HANDOFF;
      end
      HANDOFF: state_n = WAIT_DONE;
      WAIT_DONE: begin
        if (player_finished)
          state_n = STEP;
      end
      STEP: begin
        if (rst_any) begin
          load_en = 1'b1;
          state_n = play ? REQ : IDLE;
        end else if (at_bound && !WRAP) begin
          done_set = 1'b1;
          state_n  = IDLE;
        end else begin
          step_en = 1'b1;
          state_n = play ? REQ : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      rst_pend     <= 1'b0;
      sample_word  <= 32'h0;
      player_start <= 1'b0;
    end else begin
      if (load_en)      rst_pend <= 1'b0;
      else if (restart) rst_pend <= 1'b1;
      if (state == WAIT_DATA &&
          flash_mem.flash_mem_readdatavalid)
        sample_word <= flash_mem.flash_mem_readdata;
      player_start <= (state == HANDOFF);
    end
  end

`ifdef FLASH_READER_LOOP_EN
  assign song_done = 1'b0;
`else
  always_ff @(posedge clk_50MHz) begin
    if (reset)         song_done <= 1'b0;
    else if (load_en)  song_done <= 1'b0;
    else if (done_set) song_done <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_flash_reader.sv
// Directed bench for flash_reader with a one-cycle
// Avalon responder; honours FLASH_READER_LOOP_EN.
module tb_flash_reader;
  import flash_reader_pkg::*;

  localparam int              AW = 23;
  localparam logic [AW-1:0]   SA = DEF_START_ADDR;
  localparam logic [AW-1:0]   EA = DEF_END_ADDR;

  logic        clk = 1'b0;
  logic        reset, play, forward, restart;
  logic        player_finished, player_start, song_done;
  logic [31:0] sample_word;
  logic        stall, stray;
  logic [31:0] mem_word;
  logic        acc_q = 1'b0;
  int          n_acc = 0;
  int          checks = 0;
  int          errors = 0;

  always #10 clk = ~clk;

  flash_reader_if #(.ADDR_W(AW)) mem ();

  assign mem.flash_mem_waitrequest   = stall;
  assign mem.flash_mem_readdata      = mem_word;
  assign mem.flash_mem_readdatavalid = acc_q | stray;

  always @(posedge clk) begin
    acc_q <= mem.flash_mem_read & ~stall;
    if (mem.flash_mem_read && !stall)
      n_acc <= n_acc + 1;
  end

  flash_reader #(
    .ADDR_W     (AW),
    .START_ADDR (SA),
    .END_ADDR   (EA)
  ) dut (
    .clk_50MHz       (clk),
    .reset           (reset),
    .play            (play),
    .forward         (forward),
    .restart         (restart),
    .flash_mem       (mem),
    .sample_word     (sample_word),
    .player_start    (player_start),
    .player_finished (player_finished),
    .song_done       (song_done)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      tick();
      if (player_start === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic finish_pulse();
    player_finished = 1'b1;
    tick();
    player_finished = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    play  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  bit ok, stable, walk_ok, saw;
  int a0;

  initial begin
    reset = 1'b1; play = 1'b0; forward = 1'b1;
    restart = 1'b0; player_finished = 1'b0;
    stall = 1'b0; stray = 1'b0;
    mem_word = 32'hFFFF_1111;
    tick(); tick(); tick();
    reset = 1'b0;

    chk("rst_read", mem.flash_mem_read, 0);
    chk("rst_start", player_start, 0);
    chk("rst_done", song_done, 0);
    chk("rst_sample", sample_word, 0);
    chk("rst_addr", mem.flash_mem_address, SA);
    chk("rst_be", mem.flash_mem_byteenable, 4'hF);

    // first word: play -> player_start in 4 cycles
    play = 1'b1;
    tick();
    chk("t1_read", mem.flash_mem_read, 1);
    chk("t1_addr", mem.flash_mem_address, 0);
    tick(); tick();
    chk("t1_nostart3", player_start, 0);
    tick();
    chk("t1_start4", player_start, 1);
    chk("t1_sample", sample_word, 32'hFFFF_1111);
    tick();
    chk("t1_pulse1", player_start, 0);
    finish_pulse();
    chk("t1_step_noread", mem.flash_mem_read, 0);
    tick();
    chk("t1_read2", mem.flash_mem_read, 1);
    chk("t1_addr2", mem.flash_mem_address, 1);

    // stall the second read for 5 cycles
    stall = 1'b1;
    mem_word = 32'hA5A5_0001;
    a0 = n_acc;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mem.flash_mem_read !== 1'b1 ||
          mem.flash_mem_address !== 23'd1)
        stable = 1'b0;
    end
    chk("t2_stable", stable, 1);
    stall = 1'b0;
    tick();
    chk("t2_one_acc", n_acc, a0 + 1);
    chk("t2_read_off", mem.flash_mem_read, 0);
    wait_start(ok);
    chk("t2_start", ok, 1);
    chk("t2_sample", sample_word, 32'hA5A5_0001);
    chk("t2_acc_total", n_acc, a0 + 1);

    // backward to START, then past the boundary
    forward = 1'b0;
    mem_word = 32'h3333_CCCC;
    finish_pulse();
    tick();
    chk("t3_read0", mem.flash_mem_read, 1);
    chk("t3_addr0", mem.flash_mem_address, SA);
    wait_start(ok);
    chk("t3_start", ok, 1);
    chk("t3_sample", sample_word, 32'h3333_CCCC);
    finish_pulse();
    tick();
`ifdef FLASH_READER_LOOP_EN
    chk("t3_wrap_read", mem.flash_mem_read, 1);
    chk("t3_wrap_addr", mem.flash_mem_address, EA);
    chk("t3_done_loop", song_done, 0);
`else
    chk("t3_done", song_done, 1);
    chk("t3_noread", mem.flash_mem_read, 0);
    a0 = n_acc;
    for (int i = 0; i < 5; i++) tick();
    chk("t3_no_acc", n_acc, a0);
    chk("t3_done_hold", song_done, 1);
    chk("t3_addr_hold", mem.flash_mem_address, SA);
`endif

    // play drops while the read is in flight
    do_reset();
    forward = 1'b1;
    mem_word = 32'h1234_5678;
    play = 1'b1;
    tick();
    tick();
    play = 1'b0;
    wait_start(ok);
    chk("t4_start", ok, 1);
    chk("t4_sample", sample_word, 32'h1234_5678);
    finish_pulse();
    tick();
    a0 = n_acc;
    for (int i = 0; i < 4; i++) tick();
    chk("t4_idle_noread", mem.flash_mem_read, 0);
    chk("t4_idle_acc", n_acc, a0);
    chk("t4_stepped", mem.flash_mem_address, 1);
    play = 1'b1;
    tick();
    chk("t4_resume_read", mem.flash_mem_read, 1);
    chk("t4_resume_addr", mem.flash_mem_address, 1);

    // walk forward to 0x100
    walk_ok = 1'b0;
    for (int i = 0; i < 300 && !walk_ok; i++) begin
      wait_start(ok);
      if (!ok) break;
      if (mem.flash_mem_address == 23'h100)
        walk_ok = 1'b1;
      else
        finish_pulse();
    end
    chk("t5_walk", walk_ok, 1);
    chk("t5_at100", mem.flash_mem_address, 23'h100);
    restart = 1'b1;
    player_finished = 1'b1;
    tick();
    restart = 1'b0;
    player_finished = 1'b0;
    tick();
    chk("t5_rs_read", mem.flash_mem_read, 1);
    chk("t5_rs_addr", mem.flash_mem_address, SA);

    // reset with a word in flight, then a stray strobe
    mem_word = 32'hDEAD_BEEF;
    wait_start(ok);
    chk("t6_start", ok, 1);
    finish_pulse();
    tick();
    chk("t6_addr1", mem.flash_mem_address, 1);
    tick();
    chk("t6_in_wait", mem.flash_mem_read, 0);
    reset = 1'b1;
    play = 1'b0;
    tick();
    reset = 1'b0;
    stray = 1'b1;
    saw = 1'b0;
    tick();
    stray = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (player_start === 1'b1) saw = 1'b1;
      tick();
    end
    chk("t6_no_start", saw, 0);
    chk("t6_read", mem.flash_mem_read, 0);
    chk("t6_sample", sample_word, 0);
    chk("t6_addr", mem.flash_mem_address, SA);
    chk("t6_done", song_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
